// File: rtl/y86_mem_pkg.sv
// Shared constants and types for the quadword memory port arbiter.
// Holds RAM geometry, FSM state encoding and requester port ids.
package y86_mem_pkg;
    localparam int MEM_BYTES = 2048;
    localparam int QW_BYTES  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_LAST,
        ST_RESP
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // A quadword access is legal only if all of its bytes land inside the RAM.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input int          mem_bytes,
                                           input int          qw_bytes);
        return addr <= 64'(mem_bytes - qw_bytes);
    endfunction
endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin selector with a per-port eligibility mask.
// Purely combinational; the last-grant pointer lives in the caller.
module mem_rr_arb
    import y86_mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_port
);
    logic [1:0] w_elig;

    // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_elig  = i_req & ~i_mask;
        o_valid = |w_elig;
        if (&w_elig) begin
            o_port = ~i_last;
        end else begin
            o_port = w_elig[PORT_D];
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data quadword requests onto a byte-wide synchronous RAM,
// sequencing eight byte accesses per transfer and assembling read data.
module mem_port_arbiter #(
    parameter int MEM_BYTES = y86_mem_pkg::MEM_BYTES,
    parameter int QW_BYTES  = y86_mem_pkg::QW_BYTES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         if_req,
    input  logic [63:0]                  if_addr,
    output logic                         if_done,
    output logic [63:0]                  if_rdata,
    output logic                         if_err,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [63:0]                  d_addr,
    input  logic [63:0]                  d_wdata,
    output logic                         d_done,
    output logic [63:0]                  d_rdata,
    output logic                         d_err,
    output logic [$clog2(MEM_BYTES)-1:0] ram_addr,
    output logic                         ram_we,
    output logic [7:0]                   ram_wdata,
    input  logic [7:0]                   ram_rdata,
    output logic                         busy
);
    import y86_mem_pkg::*;

    localparam int            AW     = $clog2(MEM_BYTES);
    localparam int            KW     = $clog2(QW_BYTES);
    localparam logic [KW-1:0] K_LAST = KW'(QW_BYTES - 1);

    state_t        r_state;
    logic          r_port;
    logic          r_last_port;
    logic          r_we;
    logic          r_hold;
    logic [KW-1:0] r_k;
    logic [55:0]   r_wdata;
    logic [55:0]   r_rdata;

    logic [1:0]  w_req;
    logic [1:0]  w_mask;
    logic        w_gnt_valid;
    logic        w_gnt_port;
    logic [63:0] w_sel_addr;
    logic [63:0] w_sel_wdata;
    logic        w_sel_we;
    logic        w_addr_ok;
    logic [63:0] w_capture;

    assign w_req       = {d_req, if_req};
    assign w_mask      = !r_hold ? 2'b00 : ((r_port == PORT_D) ? 2'b10 : 2'b01);
    assign w_sel_addr  = (w_gnt_port == PORT_D) ? d_addr : if_addr;
    assign w_sel_wdata = (w_gnt_port == PORT_D) ? d_wdata : 64'd0;
    assign w_sel_we    = (w_gnt_port == PORT_D) && d_we;
    assign w_addr_ok   = addr_in_range(w_sel_addr, MEM_BYTES, QW_BYTES);
    // Read bytes arrive in address order, so shifting in from the top leaves byte 0 at the bottom.
    assign w_capture   = {ram_rdata, r_rdata};
    assign busy        = (r_state != ST_IDLE);

    mem_rr_arb u_arb (
        .i_req   (w_req),
        .i_mask  (w_mask),
        .i_last  (r_last_port),
        .o_valid (w_gnt_valid),
        .o_port  (w_gnt_port)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_port      <= PORT_IF;
            r_last_port <= PORT_D;
            r_we        <= 1'b0;
            r_hold      <= 1'b0;
            r_k         <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            if_done     <= 1'b0;
            if_rdata    <= '0;
            if_err      <= 1'b0;
            d_done      <= 1'b0;
            d_rdata     <= '0;
            d_err       <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; these defaults make strobes single-cycle.
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            r_hold    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_port      <= w_gnt_port;
                        r_last_port <= w_gnt_port;
                        r_we        <= w_sel_we;
                        r_k         <= '0;
                        r_rdata     <= '0;
                        r_wdata     <= w_sel_wdata[63:8];
                        if (w_addr_ok) begin
                            r_state   <= ST_XFER;
                            ram_addr  <= w_sel_addr[AW-1:0];
                            ram_we    <= w_sel_we;
                            ram_wdata <= w_sel_wdata[7:0];
                        end else begin
                            r_state <= ST_RESP;
                            if (w_gnt_port == PORT_D) begin
                                d_done  <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                if_done  <= 1'b1;
                                if_err   <= 1'b1;
                                if_rdata <= '0;
                            end
                        end
                    end
                end
                ST_XFER: begin
                    if (r_k != '0 && !r_we) begin
                        r_rdata <= w_capture[63:8];
                    end
                    if (r_k == K_LAST) begin
                        if (r_we) begin
                            r_state <= ST_RESP;
                            d_done  <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= '0;
                        end else begin
                            r_state <= ST_LAST;
                        end
                    end else begin
                        r_k       <= r_k + KW'(1);
                        ram_addr  <= ram_addr + AW'(1);
                        ram_we    <= r_we;
                        ram_wdata <= r_wdata[7:0];
                        r_wdata   <= r_wdata >> 8;
                    end
                end
                ST_LAST: begin
                    r_state <= ST_RESP;
                    if (r_port == PORT_D) begin
                        d_done  <= 1'b1;
                        d_err   <= 1'b0;
                        d_rdata <= w_capture;
                    end else begin
                        if_done  <= 1'b1;
                        if_err   <= 1'b0;
                        if_rdata <= w_capture;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte RAM model, quadword reference
// memory, directed corner cases and randomized single-port transactions.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        d_err;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;

    logic [7:0]  mem  [0:2047] = '{default: 8'h00};
    logic [7:0]  gold [0:2047] = '{default: 8'h00};
    logic [63:0] exp_rdata [2];
    logic        exp_err   [2];
    bit          rd_known  [2];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // Synchronous-read byte RAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] gold_qw(input int a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = gold[a + i];
        return r;
    endfunction

    function automatic logic [63:0] mem_qw(input int a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[a + i];
        return r;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            exp_rdata[p] = '0;
            exp_err[p]   = 1'b0;
            rd_known[p]  = 1'b1;
        end
    endtask

    // One single-port transaction; expectations come from the quadword reference memory.
    task automatic run_txn(input bit port, input bit we, input logic [63:0] addr,
                           input logic [63:0] wdata, input string tag);
        bit          eff_we;
        bit          valid;
        int          exp_lat;
        int          exp_we;
        logic [63:0] exp_rd;
        int          we0;
        int          lat;
        bit          done;
        bit          other_seen;
        logic [63:0] got_rd;
        logic        got_err;
        int          a;
        eff_we = port && we;
        valid  = (addr <= 64'd2040);
        a      = int'(addr[10:0]);
        exp_rd = '0;
        if (!valid) begin
            exp_lat = 1;
            exp_we  = 0;
        end else if (eff_we) begin
            exp_lat = 9;
            exp_we  = 8;
        end else begin
            exp_lat = 10;
            exp_we  = 0;
            exp_rd  = gold_qw(a);
        end

        @(negedge clk);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        we0        = we_cnt;
        lat        = 0;
        done       = 1'b0;
        other_seen = 1'b0;
        got_rd     = '0;
        got_err    = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                // Operands change after grant and must not affect the transfer.
                if (port) begin
                    d_req = 1'b0; d_we = 1'($urandom);
                    d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
                end else begin
                    if_req = 1'b0; if_addr = {$urandom, $urandom};
                end
            end
            if ((port ? d_done : if_done) === 1'b1) begin
                done    = 1'b1;
                got_rd  = port ? d_rdata : if_rdata;
                got_err = port ? d_err : if_err;
            end
            if ((port ? if_done : d_done) === 1'b1) other_seen = 1'b1;
        end

        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_err"}, 64'(got_err), 64'(!valid));
        if (!eff_we) check({tag, "_rdata"}, got_rd, exp_rd);
        check({tag, "_ram_we_cycles"}, 64'(we_cnt - we0), 64'(exp_we));
        check({tag, "_other_done"}, 64'(other_seen), 64'd0);
        check({tag, "_other_err_hold"}, 64'(port ? if_err : d_err), 64'(exp_err[!port]));
        if (rd_known[!port])
            check({tag, "_other_rdata_hold"}, port ? if_rdata : d_rdata, exp_rdata[!port]);

        if (valid && eff_we) begin
            for (int i = 0; i < 8; i++) gold[a + i] = wdata[8*i +: 8];
            check({tag, "_ram_bytes"}, mem_qw(a), wdata);
        end
        exp_err[port]   = !valid;
        exp_rdata[port] = exp_rd;
        rd_known[port]  = !eff_we || !valid;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          order [$];
        bit          both_seen;
        bit          prev_if;
        bit          prev_d;
        bit          double_pulse;
        int          first_lat;
        logic [63:0] first_if_rd;
        logic [63:0] wv;
        int          cyc;
        int          we0;
        bit          late_done;
        logic [63:0] addr;

        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {if_done, if_err, d_done, d_err, ram_we, busy, ram_addr, ram_wdata},
              64'd0);
        check("reset_if_rdata", if_rdata, 64'd0);
        check("reset_d_rdata", d_rdata, 64'd0);

        // Directed write then fetch of the same quadword.
        run_txn(1'b1, 1'b1, 64'h100, 64'h1122_3344_5566_7788, "d_write_0x100");
        check("byte_0x100", 64'(mem[11'h100]), 64'h88);
        check("byte_0x107", 64'(mem[11'h107]), 64'h11);
        run_txn(1'b0, 1'b0, 64'h100, 64'h0, "if_read_0x100");
        check("if_read_0x100_value", if_rdata, 64'h1122_3344_5566_7788);

        // Address boundaries.
        run_txn(1'b1, 1'b1, 64'd2040, {$urandom, $urandom}, "d_write_2040");
        run_txn(1'b1, 1'b0, 64'd2040, 64'h0, "d_read_2040");
        run_txn(1'b1, 1'b0, 64'd2041, 64'h0, "d_read_2041");
        run_txn(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, {$urandom, $urandom}, "d_write_huge");
        run_txn(1'b0, 1'b0, 64'd2048, 64'h0, "if_read_2048");

        // Both requesters held from reset: strict alternation starting with fetch.
        @(negedge clk);
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1;
        if_addr = 64'h100; d_addr = 64'h200; d_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        both_seen = 1'b0; prev_if = 1'b0; prev_d = 1'b0; double_pulse = 1'b0;
        first_lat = 0; first_if_rd = '0; cyc = 0;
        while (order.size() < 4 && cyc < 80) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (if_done && d_done) both_seen = 1'b1;
            if ((if_done && prev_if) || (d_done && prev_d)) double_pulse = 1'b1;
            prev_if = if_done;
            prev_d  = d_done;
            if (if_done) begin
                if (order.size() == 0) begin
                    first_lat   = cyc;
                    first_if_rd = if_rdata;
                end
                order.push_back(0);
            end
            if (d_done) order.push_back(1);
            if (order.size() >= 4) begin
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("rr_grant_count", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant_%0d", i),
                  64'((i < order.size()) ? order[i] : -1), 64'(i % 2));
        check("rr_no_simultaneous_done", 64'(both_seen), 64'd0);
        check("rr_single_cycle_done", 64'(double_pulse), 64'd0);
        check("rr_first_latency", 64'(first_lat), 64'd10);
        check("rr_first_if_rdata", first_if_rd, gold_qw(32'h100));
        cyc = 0;
        while (busy && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("rr_drain", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        exp_rdata[0] = gold_qw(32'h100);
        exp_rdata[1] = gold_qw(32'h200);

        // Reset in the middle of a write: bytes 0..3 land, nothing more.
        wv = {$urandom, $urandom};
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h300; d_wdata = wv;
        we0 = we_cnt;
        @(posedge clk);
        @(negedge clk);
        d_req = 1'b0; d_addr = 64'h500; d_wdata = ~wv;
        repeat (3) @(negedge clk);
        check("abort_k3_ram_we", 64'(ram_we), 64'd1);
        check("abort_k3_ram_addr", 64'(ram_addr), 64'h303);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ram_we_after_reset", 64'(ram_we), 64'd0);
        check("abort_busy_after_reset", 64'(busy), 64'd0);
        check("abort_d_rdata_cleared", d_rdata, 64'd0);
        late_done = d_done;
        repeat (12) begin
            @(negedge clk);
            if (d_done) late_done = 1'b1;
        end
        check("abort_no_done", 64'(late_done), 64'd0);
        check("abort_we_cycles", 64'(we_cnt - we0), 64'd4);
        for (int i = 0; i < 4; i++) gold[32'h300 + i] = wv[8*i +: 8];
        check("abort_ram_bytes", mem_qw(32'h300), gold_qw(32'h300));
        model_reset();

        // Randomized single-port traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) addr = 64'(2041 + $urandom_range(0, 6));
                else addr = {1'b1, 31'($urandom), $urandom};
            end else begin
                addr = 64'($urandom_range(0, 2040));
            end
            run_txn(1'($urandom), 1'($urandom), addr, {$urandom, $urandom},
                    $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
